qc_link_master: RTL and testbench

QC_LINK_MASTER -- requirements
Module: qc_link_master

---
 rtl/qc_link_master.sv | 176 +++++++++++++++++
 tb/tb_qc_link_master.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qc_link_master.sv
// Link master that streams state and gate words into a toggle-handshaked compute FSM and reads the result back.
// Optional checksum outputs (chk_sum, chk_valid) are built when QC_LINK_CHECKSUM_EN is defined.
module qc_link_master #(
  parameter int N      = 2,
  parameter int HOLD   = 4,
  parameter int SETTLE = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_gates,
  input  logic        word_valid,
  output logic        word_ready,
  input  logic [15:0] word_data,
  output logic [7:0]  load_temp,
  output logic [7:0]  load_temp2,
  output logic        load_ready,
  output logic [7:0]  new_gate,
  input  logic [7:0]  send_temp,
  input  logic [7:0]  send_temp2,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [15:0] rd_data,
  output logic        busy
`ifdef QC_LINK_CHECKSUM_EN
  ,
  output logic [15:0] chk_sum,
  output logic        chk_valid
`endif
);

  localparam int MAX        = 1 << N;
  localparam int WC_W       = $clog2(2*MAX + 255*2*MAX*MAX + 1);
  localparam int RC_W       = $clog2(2*MAX);
  localparam int HW         = $clog2(HOLD + 1);
  localparam int SETTLE_EFF = (SETTLE < 1) ? 1 : SETTLE;
  localparam int SW         = $clog2(SETTLE_EFF + 1);
  localparam logic [WC_W-1:0] STATE_WORDS = WC_W'(2*MAX);
  localparam logic [WC_W-1:0] GATE_WORDS  = WC_W'(2*MAX*MAX);

  typedef enum logic [2:0] {
    ST_IDLE, ST_LD_WAIT, ST_LD_SETUP, ST_LD_HOLD,
    ST_SETTLE, ST_RD_TOGGLE, ST_RD_HOLD, ST_RD_PUSH
  } state_t;

  state_t          state;
  logic [WC_W-1:0] wordCnt;
  logic [WC_W-1:0] wordLast;
  logic [WC_W-1:0] gateLastFirst;
  logic [RC_W-1:0] rdCnt;
  logic [HW-1:0]   holdCnt;
  logic [SW-1:0]   settleCnt;
  logic            newGate;
  logic [7:0]      gEff;

  // A zero gate count still runs one gate.
  always_comb begin
    gEff = (cmd_gates == 8'd0) ? 8'd1 : cmd_gates;
  end

  assign new_gate = {7'b0, newGate};

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      wordCnt       <= '0;
      wordLast      <= '0;
      gateLastFirst <= '0;
      rdCnt         <= '0;
      holdCnt       <= '0;
      settleCnt     <= '0;
      newGate       <= 1'b0;
      load_ready    <= 1'b0;
      load_temp     <= 8'd0;
      load_temp2    <= 8'd0;
      rd_data       <= 16'd0;
      rd_valid      <= 1'b0;
      word_ready    <= 1'b0;
      busy          <= 1'b0;
      cmd_ready     <= 1'b1;
`ifdef QC_LINK_CHECKSUM_EN
      chk_sum       <= 16'd0;
      chk_valid     <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          newGate <= 1'b0;
`ifdef QC_LINK_CHECKSUM_EN
          chk_valid <= 1'b0;
`endif
          if (cmd_valid) begin
            wordLast      <= STATE_WORDS + WC_W'(gEff) * GATE_WORDS - WC_W'(1);
            gateLastFirst <= STATE_WORDS + (WC_W'(gEff) - WC_W'(1)) * GATE_WORDS;
            wordCnt       <= '0;
            rdCnt         <= '0;
            newGate       <= 1'b1;
            cmd_ready     <= 1'b0;
            busy          <= 1'b1;
            word_ready    <= 1'b1;
            state         <= ST_LD_WAIT;
`ifdef QC_LINK_CHECKSUM_EN
            chk_sum       <= 16'd0;
`endif
          end
        end
        ST_LD_WAIT: begin
          if (word_valid) begin
            {load_temp, load_temp2} <= word_data;
            word_ready <= 1'b0;
            if (wordCnt == gateLastFirst) newGate <= 1'b0;
            state <= ST_LD_SETUP;
          end
        end
        ST_LD_SETUP: begin
          // Even word index = real part = strobe high.
          load_ready <= ~wordCnt[0];
          holdCnt    <= HW'(HOLD - 1);
          state      <= ST_LD_HOLD;
        end
        ST_LD_HOLD: begin
          if (holdCnt != '0) begin
            holdCnt <= holdCnt - HW'(1);
          end else if (wordCnt == wordLast) begin
            settleCnt <= SW'(SETTLE_EFF - 1);
            state     <= ST_SETTLE;
          end else begin
            wordCnt    <= wordCnt + WC_W'(1);
            word_ready <= 1'b1;
            state      <= ST_LD_WAIT;
          end
        end
        ST_SETTLE: begin
          if (settleCnt != '0) settleCnt <= settleCnt - SW'(1);
          else state <= ST_RD_TOGGLE;
        end
        ST_RD_TOGGLE: begin
          load_ready <= ~rdCnt[0];
          holdCnt    <= HW'(HOLD - 1);
          state      <= ST_RD_HOLD;
        end
        ST_RD_HOLD: begin
          if (holdCnt != '0) begin
            holdCnt <= holdCnt - HW'(1);
          end else begin
            rd_data  <= {send_temp, send_temp2};
            rd_valid <= 1'b1;
            state    <= ST_RD_PUSH;
          end
        end
        ST_RD_PUSH: begin
          if (rd_ready) begin
            rd_valid <= 1'b0;
`ifdef QC_LINK_CHECKSUM_EN
            chk_sum  <= chk_sum + rd_data;
`endif
            if (rdCnt == RC_W'(2*MAX - 1)) begin
              busy      <= 1'b0;
              cmd_ready <= 1'b1;
              state     <= ST_IDLE;
`ifdef QC_LINK_CHECKSUM_EN
              chk_valid <= 1'b1;
`endif
            end else begin
              rdCnt <= rdCnt + RC_W'(1);
              state <= ST_RD_TOGGLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qc_link_master.sv
// Scoreboard bench for qc_link_master: a behavioural compute-FSM responder plus permutation-based expected results.
// Define QC_LINK_CHECKSUM_EN to also check the checksum outputs.
module tb_qc_link_master;
  localparam int N = 2, MAX = 4, NW = 2*MAX, GW = 2*MAX*MAX, HOLD = 4, SETTLE = 16;

  logic clk = 1'b0, reset = 1'b0;
  logic cmd_valid = 1'b0, cmd_ready;
  logic [7:0] cmd_gates = 8'd0;
  logic word_valid = 1'b0, word_ready;
  logic [15:0] word_data = 16'd0;
  logic [7:0] load_temp, load_temp2, new_gate;
  logic load_ready;
  logic [7:0] send_temp = 8'd0, send_temp2 = 8'd0;
  logic rd_valid, rd_ready = 1'b0;
  logic [15:0] rd_data;
  logic busy;
`ifdef QC_LINK_CHECKSUM_EN
  logic [15:0] chk_sum;
  logic chk_valid;
  logic [15:0] sumAcc = 16'd0;
`endif

  qc_link_master #(.N(N), .HOLD(HOLD), .SETTLE(SETTLE)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_gates(cmd_gates),
    .word_valid(word_valid), .word_ready(word_ready), .word_data(word_data),
    .load_temp(load_temp), .load_temp2(load_temp2), .load_ready(load_ready), .new_gate(new_gate),
    .send_temp(send_temp), .send_temp2(send_temp2), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .busy(busy)
`ifdef QC_LINK_CHECKSUM_EN
    , .chk_sum(chk_sum), .chk_valid(chk_valid)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {logic [15:0] data; logic lr; logic ng;} ld_exp_t;
  ld_exp_t     qLoad[$];
  logic [15:0] qRd[$];
  logic [15:0] rx[$];
  logic [15:0] res[NW];
  logic [15:0] stv[NW];
  int          masks[$];
  int checks = 0, errors = 0;
  int cycle = 0, loadTotal = NW + GW, tcount = 0, lastToggle = -1000;
  logic prevLr = 1'b0;
  logic [15:0] prevLd = 16'd0;
  bit rdStallArm = 1'b0;
  int rdStallCnt = 0;
  logic pValid = 1'b0, pReady = 1'b0, pLr = 1'b0;
  logic [15:0] pData = 16'd0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // Generic Q8.8 complex matrix-vector products over whatever the responder received.
  function automatic void computeResult();
    int vr[MAX], vi[MAX], nr[MAX], ni[MAX];
    int g, base, mr, mi;
    g = (loadTotal - NW) / GW;
    for (int k = 0; k < MAX; k++) begin
      vr[k] = int'($signed(rx[2*k]));
      vi[k] = int'($signed(rx[2*k+1]));
    end
    for (int gi = 0; gi < g; gi++) begin
      base = NW + gi*GW;
      for (int r = 0; r < MAX; r++) begin
        nr[r] = 0; ni[r] = 0;
        for (int c = 0; c < MAX; c++) begin
          mr = int'($signed(rx[base + 2*(r*MAX+c)]));
          mi = int'($signed(rx[base + 2*(r*MAX+c) + 1]));
          nr[r] += mr*vr[c] - mi*vi[c];
          ni[r] += mr*vi[c] + mi*vr[c];
        end
      end
      for (int r = 0; r < MAX; r++) begin
        vr[r] = nr[r] >>> 8;
        vi[r] = ni[r] >>> 8;
      end
    end
    for (int r = 0; r < MAX; r++) begin
      res[2*r]   = 16'(vr[r]);
      res[2*r+1] = 16'(vi[r]);
    end
  endfunction

  // Compute-FSM responder and load-side monitor.
  always @(negedge clk) begin
    if (reset) begin
      prevLr = 1'b0; tcount = 0; lastToggle = -1000; rx.delete();
    end else begin
      if (load_ready !== prevLr) begin
        check("toggle_gap_ok", 32'(cycle - lastToggle >= HOLD + 1), 32'd1);
        if (tcount < loadTotal) begin
          if (qLoad.size() == 0) begin
            check("load_unexpected", 32'(tcount), 32'hffffffff);
          end else begin
            ld_exp_t e;
            e = qLoad.pop_front();
            check("load_word", {load_temp, load_temp2}, e.data);
            check("load_parity", load_ready, e.lr);
            check("new_gate", new_gate, {7'b0, e.ng});
            check("load_stable", prevLd, {load_temp, load_temp2});
          end
          rx.push_back({load_temp, load_temp2});
          if (tcount == loadTotal - 1) computeResult();
        end else begin
          if (tcount == loadTotal) check("settle_gap_ok", 32'(cycle - lastToggle >= SETTLE + 1), 32'd1);
          check("rd_parity", load_ready, ((tcount - loadTotal) % 2) == 0);
          {send_temp, send_temp2} = res[tcount - loadTotal];
        end
        tcount++;
        if (tcount == loadTotal + NW) begin tcount = 0; rx.delete(); end
        lastToggle = cycle;
        prevLr = load_ready;
      end
      prevLd = {load_temp, load_temp2};
    end
  end

  // Readback ready driver and monitor.
  always @(negedge clk) begin
    if (reset) begin
      rd_ready = 1'b0; pValid = 1'b0; pReady = 1'b0; rdStallCnt = 0;
    end else begin
      if (rdStallArm && rd_valid) begin rdStallArm = 1'b0; rdStallCnt = 20; end
      if (rdStallCnt > 0) begin rd_ready = 1'b0; rdStallCnt--; end
      else rd_ready = ($urandom_range(0, 3) != 0);
      if (pValid && !pReady) begin
        check("rd_hold_valid", rd_valid, 1'b1);
        check("rd_hold_data", rd_data, pData);
        check("rd_hold_strobe", load_ready, pLr);
      end
      if (rd_valid && rd_ready) begin
        if (qRd.size() == 0) check("rd_unexpected", rd_data, 32'hffffffff);
        else check("rd_data", rd_data, qRd.pop_front());
`ifdef QC_LINK_CHECKSUM_EN
        sumAcc = sumAcc + rd_data;
`endif
      end
`ifdef QC_LINK_CHECKSUM_EN
      if (chk_valid) check("chk_sum", chk_sum, sumAcc);
`endif
      pValid = rd_valid; pReady = rd_ready; pData = rd_data; pLr = load_ready;
    end
  end

  task automatic runOne(input logic [7:0] cg, input int dropAt, input int resetAt,
                        input bit poke, input bit rdStall);
    logic [15:0] words[$];
    int g, wTot, k, guard, tm, lastFirst;
    bit acc, dropped;
    logic lrSnap;
    g = (cg == 8'd0) ? 1 : int'(cg);
    wTot = NW + g*GW;
    lastFirst = NW + (g-1)*GW;
    tm = 0;
    for (int i = 0; i < NW; i++) words.push_back(stv[i]);
    for (int gi = 0; gi < g; gi++) begin
      tm ^= masks[gi];
      for (int r = 0; r < MAX; r++)
        for (int c = 0; c < MAX; c++) begin
          words.push_back((c == (r ^ masks[gi])) ? 16'h0100 : 16'h0000);
          words.push_back(16'h0000);
        end
    end
    for (int i = 0; i < wTot; i++) qLoad.push_back('{words[i], (i % 2) == 0, i < lastFirst});
    // X gates only permute amplitudes: final[r] = initial[r ^ xor of masks].
    for (int r = 0; r < MAX; r++) begin
      qRd.push_back(stv[2*(r ^ tm)]);
      qRd.push_back(stv[2*(r ^ tm) + 1]);
    end
    loadTotal = wTot;
    rdStallArm = rdStall;
`ifdef QC_LINK_CHECKSUM_EN
    sumAcc = 16'd0;
`endif
    @(negedge clk);
    check("cmd_ready_idle", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_gates = cg;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("busy_after_cmd", busy, 1'b1);
    k = 0; guard = 0; dropped = 0;
    while (k < wTot) begin
      if (resetAt >= 0 && k == resetAt) begin
        reset = 1'b1; word_valid = 1'b0;
        @(negedge clk);
        check("rst_load_ready", load_ready, 1'b0);
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_word_ready", word_ready, 1'b0);
        qLoad.delete(); qRd.delete();
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      if (k == dropAt && !dropped) begin
        dropped = 1;
        word_valid = 1'b0;
        repeat (10) @(negedge clk);
        lrSnap = load_ready;
        repeat (40) @(negedge clk);
        check("drop_frozen", load_ready, lrSnap);
        check("drop_word_ready", word_ready, 1'b1);
      end
      cmd_valid = poke && k >= 30 && k < 33;
      cmd_gates = 8'd7;
      if (cmd_valid) check("cmd_ready_busy", cmd_ready, 1'b0);
      word_valid = ($urandom_range(0, 4) != 0);
      word_data = words[k];
      acc = word_valid && word_ready;
      @(negedge clk);
      if (acc) k++;
      guard++;
      if (guard > 20000) begin
        checks++; errors++;
        $display("FAIL word_loop_timeout accepted %0d of %0d", k, wTot);
        break;
      end
    end
    word_valid = 1'b0; cmd_valid = 1'b0;
    guard = 0;
    while ((busy || qRd.size() != 0) && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    check("run_done_in_time", 32'(guard < 5000), 32'd1);
    @(negedge clk);
    check("done_busy", busy, 1'b0);
    check("done_cmd_ready", cmd_ready, 1'b1);
    check("done_new_gate", new_gate, 8'd0);
    check("done_load_ready", load_ready, 1'b0);
    check("done_qload_empty", 32'(qLoad.size()), 32'd0);
  endtask

  task automatic randomState();
    for (int i = 0; i < NW; i++) stv[i] = 16'($urandom);
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_load_ready", load_ready, 1'b0);
    check("reset_cmd_ready", cmd_ready, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_word_ready", word_ready, 1'b0);
    check("reset_rd_valid", rd_valid, 1'b0);
    check("reset_rd_data", rd_data, 16'd0);
    check("reset_new_gate", new_gate, 8'd0);
    check("reset_load_temp", {load_temp, load_temp2}, 16'd0);
    reset = 1'b0;

    for (int i = 0; i < NW; i++) stv[i] = (i % 2 == 0) ? 16'h0100 : 16'h0000;
    masks = '{0};
    runOne(8'd1, -1, -1, 0, 0);

    randomState();
    masks = '{1, 2, 3};
    runOne(8'd3, 20, -1, 1, 1);

    randomState();
    masks = '{1, 2};
    runOne(8'd2, -1, 17, 0, 0);

    randomState();
    masks = '{$urandom_range(1, 3)};
    runOne(8'd0, -1, -1, 0, 0);

    for (int r = 0; r < 2; r++) begin
      int g;
      g = $urandom_range(1, 3);
      randomState();
      masks.delete();
      for (int i = 0; i < g; i++) masks.push_back($urandom_range(0, 3));
      runOne(8'(g), -1, -1, 0, r == 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
